// File: rtl/nibble_serial_adder.sv
// Purpose : WIDTH-bit adder that reuses one external 4-bit adder stage, one nibble per cycle, LSB first.
// Latency : result valid N = WIDTH/4 cycles after the accepting edge; one addition per N+2 cycles back-to-back.
// Backpres: in_ready only in IDLE (operands not buffered); result held in DONE until out_ready is sampled high.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake, op_a/op_b/cin sampled on accept
//   fa_A/fa_B/fa_Cin         nibble operands and carry towards the external adder stage
//   fa_Sum/fa_Carry          combinational result of the external adder stage
//   out_valid/out_ready      result handshake, sum/cout registered
//   busy                     high while an addition is in flight or awaiting hand-off
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [3:0]       fa_A,
    output logic [3:0]       fa_B,
    output logic             fa_Cin,
    input  logic [3:0]       fa_Sum,
    input  logic             fa_Carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Result shift register next value: new nibble enters at the top,
    // everything moves down one nibble. Built via a wide concatenation so
    // the same expression also works for WIDTH == 4.
    logic [WIDTH+3:0] res_cat;
    logic [WIDTH-1:0] res_d;
    logic             unused_res_low;

    assign res_cat        = {fa_Sum, res_sh_q};
    assign res_d          = res_cat[WIDTH+3:4];
    assign unused_res_low = ^res_cat[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= op_a;
                        b_sh_q     <= op_b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                S_RUN: begin
                    // After N shifts the operand registers are all zero, so
                    // fa_A/fa_B naturally read 0 outside RUN.
                    a_sh_q   <= a_sh_q >> 4;
                    b_sh_q   <= b_sh_q >> 4;
                    res_sh_q <= res_d;
                    if (cnt_q == CNT_LAST) begin
                        sum_q       <= res_d;
                        cout_q      <= fa_Carry;
                        // Carry is captured in cout; clearing it keeps fa_Cin
                        // at 0 in DONE/IDLE without gating the output.
                        carry_q     <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        carry_q <= fa_Carry;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign fa_A      = a_sh_q[3:0];
    assign fa_B      = b_sh_q[3:0];
    assign fa_Cin    = carry_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
